// File: rtl/seat_pkg.sv
// Shared types for the seat-table command path: seat states, command record, table geometry.
package seat_pkg;

  localparam int unsigned SEATS  = 32;
  localparam int unsigned TIME_W = 11;

  typedef enum logic [1:0] {
    SEAT_EMPTY = 2'd0,
    SEAT_AWAY  = 2'd1,
    SEAT_INUSE = 2'd2,
    SEAT_RSVD  = 2'd3
  } seat_state_e;

  typedef struct packed {
    logic [31:0]                student;
    logic [$clog2(SEATS)-1:0]   seat;
    seat_state_e                state;
  } seat_cmd_t;

endpackage

// File: rtl/seat_req_fifo.sv
// Synchronous request FIFO of seat commands with flush; DEPTH must be a power of two.
module seat_req_fifo
  import seat_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned CntW = $clog2(DEPTH) + 1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            push_i,
  input  logic            pop_i,
  input  logic            flush_i,
  input  seat_cmd_t       wdata_i,
  output seat_cmd_t       rdata_o,
  output logic [CntW-1:0] count_o
);
  localparam int unsigned PtrW = $clog2(DEPTH);

  seat_cmd_t       mem_q [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/seat_cmd_issuer.sv
// Seat-table write initiator: buffers front-end requests and replays them as timed write/clear
// strobes; also owns the table's tick time base and away-timeout limit.
module seat_cmd_issuer
  import seat_pkg::*;
#(
  parameter int unsigned DEPTH           = 4,
  parameter int unsigned HOLD_CYCLES     = 2,
  parameter int unsigned GAP_CYCLES      = 1,
  parameter int unsigned CYCLES_PER_TICK = 1000,
  parameter int unsigned LIMIT_DEFAULT   = 30
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [31:0]            req_student,
  input  logic [4:0]             req_seat,
  input  logic [1:0]             req_state,
  input  logic                   clr_req,
  input  logic                   cfg_we,
  input  logic [TIME_W-1:0]      cfg_limit,
  output logic                   err_drop,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   write_mem,
  output logic                   rst_mem,
  output logic [31:0]            Student_No_mem,
  output logic [4:0]             Seat_No_mem,
  output logic [1:0]             Seat_State_mem,
  output logic [TIME_W-1:0]      Time_mem,
  output logic [TIME_W-1:0]      limit_time
);
  localparam int unsigned CntW  = $clog2(DEPTH) + 1;
  localparam int unsigned PreW  = $clog2(CYCLES_PER_TICK);
  localparam int unsigned StepW = 16;

  typedef enum logic [1:0] {StIdle, StDrive, StGap, StClear} state_e;

  state_e            state_q, state_d;
  logic [StepW-1:0]  step_q, step_d;
  seat_cmd_t         cmd_q, cmd_d, head, req_cmd;
  logic              accept, push, pop, hold_done, gap_done, tick;
  logic              err_drop_q, pend_q, pend_d;
  logic [PreW-1:0]   presc_q, presc_d;
  logic [TIME_W-1:0] time_q, time_d, limit_q;

  assign req_ready = (fifo_count != CntW'(DEPTH)) && !clr_req;
  assign accept    = req_valid && req_ready;
  assign push      = accept && (req_student != '0);
  assign req_cmd   = '{student: req_student, seat: req_seat, state: seat_state_e'(req_state)};

  seat_req_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (clr_req),
    .wdata_i (req_cmd),
    .rdata_o (head),
    .count_o (fifo_count)
  );

  assign hold_done = (step_q == StepW'(HOLD_CYCLES - 1));
  assign gap_done  = (step_q == StepW'(GAP_CYCLES - 1));

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    cmd_d   = cmd_q;
    pop     = 1'b0;
    if (clr_req) begin
      state_d = StClear;
      step_d  = '0;
      cmd_d   = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (fifo_count != '0) begin
            pop     = 1'b1;
            cmd_d   = head;
            state_d = StDrive;
            step_d  = '0;
          end
        end
        StDrive, StClear: begin
          if (hold_done) begin
            state_d = StGap;
            step_d  = '0;
          end else begin
            step_d = step_q + 1'b1;
          end
        end
        StGap: begin
          // The last gap cycle launches the next queued command directly to keep the
          // back-to-back period at HOLD_CYCLES + GAP_CYCLES.
          if (gap_done) begin
            step_d = '0;
            if (fifo_count != '0) begin
              pop     = 1'b1;
              cmd_d   = head;
              state_d = StDrive;
            end else begin
              state_d = StIdle;
            end
          end else begin
            step_d = step_q + 1'b1;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  assign tick = (presc_q == PreW'(CYCLES_PER_TICK - 1));

  // Time must not move under an active write strobe; a tick seen then is deferred, not lost.
  always_comb begin
    presc_d = tick ? '0 : presc_q + 1'b1;
    time_d  = time_q;
    pend_d  = pend_q;
    if (tick || pend_q) begin
      if (write_mem) begin
        pend_d = 1'b1;
      end else begin
        time_d = time_q + 1'b1;
        pend_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      step_q     <= '0;
      cmd_q      <= '0;
      err_drop_q <= 1'b0;
      presc_q    <= '0;
      pend_q     <= 1'b0;
      time_q     <= '0;
      limit_q    <= TIME_W'(LIMIT_DEFAULT);
    end else begin
      state_q    <= state_d;
      step_q     <= step_d;
      cmd_q      <= cmd_d;
      err_drop_q <= accept && (req_student == '0);
      presc_q    <= presc_d;
      pend_q     <= pend_d;
      time_q     <= time_d;
      if (cfg_we) limit_q <= cfg_limit;
    end
  end

  assign write_mem      = (state_q == StDrive);
  assign rst_mem        = (state_q == StClear);
  assign busy           = (state_q != StIdle) || (fifo_count != '0);
  assign err_drop       = err_drop_q;
  assign Student_No_mem = cmd_q.student;
  assign Seat_No_mem    = cmd_q.seat;
  assign Seat_State_mem = cmd_q.state;
  assign Time_mem       = time_q;
  assign limit_time     = limit_q;

endmodule
